// File: rtl/mux_key_reg_unit.sv
// -----------------------------------------------------------------------------
// mux_key_reg_unit
//
// Key/data lookup multiplexer with a default value, followed by a
// write-enabled holding register.
//
// The packed table lut_i holds NR_KEY pairs. Pair i sits in
// lut_i[(i+1)*P-1 : i*P], where P = KEY_LEN + DATA_LEN. In each pair the key
// occupies the upper KEY_LEN bits and the data word the lower DATA_LEN bits.
// Because the first pair written in a concatenation lands at the highest
// index, "first-listed" means "highest index".
//
// Outputs:
//   hit_o     - combinational; high when any table key equals key_i.
//   mux_out_o - combinational; selected data, or default_out_i on a miss.
//   q_o       - registered copy of mux_out_o, loaded on clock edges where
//               wen_i is high. Synchronous active-high reset loads RESET_VAL.
//
// Configuration macro: MUX_KEY_PRIORITY_EN
//   undefined (default) - several matching pairs give the OR of their data.
//   defined             - several matching pairs give the data of the
//                         highest-index (first-listed) matching pair.
// hit_o, the default path and q_o behave the same in both builds.
// -----------------------------------------------------------------------------
module mux_key_reg_unit #(
    parameter int                  NR_KEY    = 2,
    parameter int                  KEY_LEN   = 1,
    parameter int                  DATA_LEN  = 1,
    parameter logic [DATA_LEN-1:0] RESET_VAL = {DATA_LEN{1'b0}}
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [KEY_LEN-1:0]                    key_i,
    input  logic [DATA_LEN-1:0]                   default_out_i,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut_i,
    input  logic                                  wen_i,
    output logic [DATA_LEN-1:0]                   mux_out_o,
    output logic                                  hit_o,
    output logic [DATA_LEN-1:0]                   q_o
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    logic [NR_KEY-1:0]   match_s;     // one bit per table pair whose key equals key_i
    logic [DATA_LEN-1:0] sel_data_s;  // data chosen among the matching pairs
    logic                hit_s;       // any pair matched
    logic [DATA_LEN-1:0] mux_out_s;   // final lookup result including default
    logic [DATA_LEN-1:0] q_d;         // next value of the holding register
    logic [DATA_LEN-1:0] q_q;         // holding register

    // Compare key_i against the key field of every table pair.
    always_comb begin
        match_s = {NR_KEY{1'b0}};
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut_i[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key_i) begin
                match_s[i] = 1'b1;
            end else begin
                match_s[i] = 1'b0;
            end
        end
    end

`ifdef MUX_KEY_PRIORITY_EN
    // Choose the data of the highest-index matching pair; later iterations
    // overwrite earlier ones, so the highest index wins.
    always_comb begin
        sel_data_s = {DATA_LEN{1'b0}};
        for (int i = 0; i < NR_KEY; i++) begin
            if (match_s[i]) begin
                sel_data_s = lut_i[i*PAIR_LEN +: DATA_LEN];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end
`else
    // OR together the data of every matching pair; a single match therefore
    // passes its data word through unchanged.
    always_comb begin
        sel_data_s = {DATA_LEN{1'b0}};
        for (int i = 0; i < NR_KEY; i++) begin
            sel_data_s = sel_data_s
                       | (lut_i[i*PAIR_LEN +: DATA_LEN] & {DATA_LEN{match_s[i]}});
        end
    end
`endif

    // Fall back to the default value when no pair matched.
    always_comb begin
        hit_s = |match_s;
        if (hit_s) begin
            mux_out_s = sel_data_s;
        end else begin
            mux_out_s = default_out_i;
        end
    end

    // Next-state for the holding register: load the lookup result or hold.
    always_comb begin
        if (wen_i) begin
            q_d = mux_out_s;
        end else begin
            q_d = q_q;
        end
    end

    // Holding register; reset takes priority over a simultaneous load.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign hit_o     = hit_s;
    assign mux_out_o = mux_out_s;
    assign q_o       = q_q;

endmodule

// File: tb/tb_mux_key_reg_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mux_key_reg_unit. Directed scenarios use dedicated
// instances with their own parameters; a randomized run on a small instance
// is compared against a behavioural lookup model built from the pair layout.
// Compile with +define+MUX_KEY_PRIORITY_EN to check the priority build.
// -----------------------------------------------------------------------------
module tb_mux_key_reg_unit;

    logic clock;
    logic rst;
    int   n_checks;
    int   n_errors;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- randomized instance: 4 pairs, 3-bit key, 8-bit data
    logic [2:0]  r_key;
    logic [7:0]  r_def;
    logic [43:0] r_lut;
    logic        r_wen;
    logic [7:0]  r_mux, r_q;
    logic        r_hit;

    mux_key_reg_unit #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8), .RESET_VAL(8'hA5)) u_rand (
        .clock(clock), .reset(rst), .key_i(r_key), .default_out_i(r_def),
        .lut_i(r_lut), .wen_i(r_wen), .mux_out_o(r_mux), .hit_o(r_hit), .q_o(r_q));

    // ---------------- scenario 1: 4 pairs, 2-bit key, 32-bit data
    logic [1:0]   s1_key;
    logic [135:0] s1_lut;
    logic [31:0]  s1_mux, s1_q;
    logic         s1_hit;

    mux_key_reg_unit #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(32)) u_s1 (
        .clock(clock), .reset(rst), .key_i(s1_key), .default_out_i(32'hDEADBEEF),
        .lut_i(s1_lut), .wen_i(1'b0), .mux_out_o(s1_mux), .hit_o(s1_hit), .q_o(s1_q));

    // ---------------- scenario 2: 3 pairs, 32-bit key, 32-bit data
    logic [31:0]  s2_key;
    logic [191:0] s2_lut;
    logic [31:0]  s2_mux, s2_q;
    logic         s2_hit;

    mux_key_reg_unit #(.NR_KEY(3), .KEY_LEN(32), .DATA_LEN(32)) u_s2 (
        .clock(clock), .reset(rst), .key_i(s2_key), .default_out_i(32'h0),
        .lut_i(s2_lut), .wen_i(1'b0), .mux_out_o(s2_mux), .hit_o(s2_hit), .q_o(s2_q));

    // ---------------- scenario 3: duplicate keys
    logic [1:0]  s3_key;
    logic [27:0] s3_lut;
    logic [11:0] s3_mux, s3_q;
    logic        s3_hit;

    mux_key_reg_unit #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(12)) u_s3 (
        .clock(clock), .reset(rst), .key_i(s3_key), .default_out_i(12'hABC),
        .lut_i(s3_lut), .wen_i(1'b0), .mux_out_o(s3_mux), .hit_o(s3_hit), .q_o(s3_q));

    // ---------------- scenarios 4/5: register behaviour, RESET_VAL=0x80000000
    logic [31:0] s4_data;
    logic        s4_wen;
    logic [31:0] s4_mux, s4_q;
    logic        s4_hit;

    mux_key_reg_unit #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h80000000)) u_s4 (
        .clock(clock), .reset(rst), .key_i(1'b0), .default_out_i(32'hFFFFFFFF),
        .lut_i({1'b0, s4_data}), .wen_i(s4_wen), .mux_out_o(s4_mux), .hit_o(s4_hit), .q_o(s4_q));

    // Single comparison point: counts every check, reports any mismatch.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural lookup: unpack the table pair by pair and apply the
    // match rules directly.
    task automatic model_lookup(input logic [2:0] k, input logic [43:0] l, input logic [7:0] d,
                                output logic h, output logic [7:0] m);
        logic [43:0] sh;
        logic [7:0]  acc;
        logic        found;
        h = 1'b0;
        acc = 8'h00;
        found = 1'b0;
        // walk from the highest index (first-listed) down to index 0
        for (int i = 3; i >= 0; i--) begin
            sh = l >> (i * 11);
            if (sh[10:8] == k) begin
                h = 1'b1;
`ifdef MUX_KEY_PRIORITY_EN
                if (!found) acc = sh[7:0];
`else
                acc = acc | sh[7:0];
`endif
                found = 1'b1;
            end
        end
        m = h ? acc : d;
    endtask

    initial begin
        logic [7:0]  exp_q;
        logic [7:0]  exp_mux;
        logic        exp_hit;
        logic [31:0] tmp;

        n_checks = 0;
        n_errors = 0;

        // ---- reset with wen held high (scenario 4, and reset of everything)
        rst     = 1'b1;
        r_key   = 3'd0;
        r_def   = 8'h00;
        r_lut   = 44'h0;
        r_wen   = 1'b1;
        s1_key  = 2'd0;
        s1_lut  = {2'b00, 32'h11111111, 2'b01, 32'h22222222,
                   2'b10, 32'h33333333, 2'b11, 32'h44444444};
        s2_key  = 32'h0;
        s2_lut  = {32'h000000FF, 32'hAAAA0001, 32'h0000FFFF, 32'hBBBB0002,
                   32'hFFFFFFFF, 32'hCCCC0003};
        s3_key  = 2'b01;
        s3_lut  = {2'b01, 12'h0F0, 2'b01, 12'hF00};
        s4_data = 32'h00001234;
        s4_wen  = 1'b1;

        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1;
            check_val("s4_q_in_reset", {32'h0, s4_q}, 64'h80000000);
            check_val("s4_mux_in_reset", {32'h0, s4_mux}, 64'h1234);
        end
        check_val("rand_q_reset", {56'h0, r_q}, 64'hA5);
        check_val("s1_q_reset", {32'h0, s1_q}, 64'h0);

        @(negedge clock);
        rst = 1'b0;
        r_wen = 1'b0;
        @(posedge clock);
        #1;
        check_val("s4_q_first_load", {32'h0, s4_q}, 64'h1234);

        // ---- scenario 5: hold while wen low, then a one-cycle pulse
        @(negedge clock);
        s4_wen  = 1'b0;
        s4_data = 32'h00005678;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            check_val("s4_q_hold", {32'h0, s4_q}, 64'h1234);
        end
        @(negedge clock);
        s4_wen = 1'b1;
        @(negedge clock);
        s4_wen = 1'b0;
        check_val("s4_q_pulse", {32'h0, s4_q}, 64'h5678);
        @(posedge clock);
        #1;
        check_val("s4_q_after_pulse", {32'h0, s4_q}, 64'h5678);

        // ---- scenario 1: key sweep
        for (int k = 0; k < 4; k++) begin
            s1_key = k[1:0];
            #1;
            tmp = 32'h11111111 * (k + 1);
            check_val("s1_mux", {32'h0, s1_mux}, {32'h0, tmp});
            check_val("s1_hit", {63'h0, s1_hit}, 64'h1);
        end

        // ---- scenario 2: wide keys
        s2_key = 32'h0000F000;
        #1;
        check_val("s2_miss_mux", {32'h0, s2_mux}, 64'h0);
        check_val("s2_miss_hit", {63'h0, s2_hit}, 64'h0);
        s2_key = 32'h0000FFFF;
        #1;
        check_val("s2_second_mux", {32'h0, s2_mux}, 64'hBBBB0002);
        check_val("s2_second_hit", {63'h0, s2_hit}, 64'h1);
        s2_key = 32'hFFFFFFFF;
        #1;
        check_val("s2_third_mux", {32'h0, s2_mux}, 64'hCCCC0003);

        // ---- scenario 3: duplicate keys
        s3_key = 2'b01;
        #1;
`ifdef MUX_KEY_PRIORITY_EN
        check_val("s3_dup_mux", {52'h0, s3_mux}, 64'h0F0);
`else
        check_val("s3_dup_mux", {52'h0, s3_mux}, 64'hFF0);
`endif
        check_val("s3_dup_hit", {63'h0, s3_hit}, 64'h1);
        s3_key = 2'b10;
        #1;
        check_val("s3_default_mux", {52'h0, s3_mux}, 64'hABC);
        check_val("s3_default_hit", {63'h0, s3_hit}, 64'h0);

        // ---- randomized run against the behavioural model
        exp_q = r_q === 8'hA5 ? 8'hA5 : 8'hA5;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            r_key = 3'($urandom_range(0, 7));
            r_def = 8'($urandom);
            r_lut = {12'($urandom), 32'($urandom)};
            r_wen = 1'($urandom);
            rst   = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            #1;
            model_lookup(r_key, r_lut, r_def, exp_hit, exp_mux);
            check_val("rand_mux", {56'h0, r_mux}, {56'h0, exp_mux});
            check_val("rand_hit", {63'h0, r_hit}, {63'h0, exp_hit});
            if (rst) exp_q = 8'hA5;
            else if (r_wen) exp_q = exp_mux;
            @(posedge clock);
            #1;
            check_val("rand_q", {56'h0, r_q}, {56'h0, exp_q});
        end

        check_val("s1_q_idle", {32'h0, s1_q}, 64'h0);
        check_val("s2_q_idle", {32'h0, s2_q}, 64'h0);
        check_val("s3_q_idle", {52'h0, s3_q}, 64'h0);
        check_val("s4_hit_const", {63'h0, s4_hit}, 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
